uart_tx_arbiter: RTL and testbench



---
 rtl/uart_arb_pkg.sv | 18 +
 rtl/rr_pick.sv | 31 +++
 rtl/uart_tx_arbiter.sv | 138 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART TX arbiter and its round-robin picker.
package uart_arb_pkg;

  // Arbiter FSM encoding: no owner / a requester owns the TX stream.
  typedef enum logic {
    S_IDLE = 1'b0,
    S_XFER = 1'b1
  } arb_state_e;

  // Width of the per-grant byte counter; MAX_BURST is capped at 255 so it never wraps.
  localparam int unsigned BURST_W = 8;

  // Number of bits needed to name one of n requesters (at least one bit).
  function automatic int unsigned grant_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping modulo N.
module rr_pick #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         found,
  output logic [W-1:0] idx
);

  logic [W:0]   sum;
  logic [W-1:0] cand;

  // Walk the N candidates starting at ptr and latch the first one requesting.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    sum   = '0;
    cand  = '0;
    for (int unsigned i = 0; i < N; i++) begin
      sum  = {1'b0, ptr} + (W+1)'(i);
      cand = (sum >= (W+1)'(N)) ? W'(sum - (W+1)'(N)) : W'(sum);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-atomic round-robin arbiter sharing one UART TX byte stream among NUM_REQ requesters.
// Optional build macro UART_ARB_TIMEOUT_EN: revoke a grant after IDLE_TIMEOUT consecutive
// cycles in which the owner holds valid low.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned MAX_BURST    = 16,
  parameter int unsigned IDLE_TIMEOUT = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [grant_w(NUM_REQ)-1:0]   grant_id,
  output logic                          busy
);

  localparam int unsigned GRANT_W = grant_w(NUM_REQ);
  localparam bit PARAMS_OK = (NUM_REQ >= 2) && (NUM_REQ <= 8) &&
                             (MAX_BURST >= 1) && (MAX_BURST <= 255) &&
                             (IDLE_TIMEOUT >= 1) && (DATA_WIDTH >= 1);

  if (!PARAMS_OK) begin : g_param_err
    $error("uart_tx_arbiter: parameter out of range");
  end

  arb_state_e            state;
  logic [GRANT_W-1:0]    rr_ptr;
  logic [BURST_W-1:0]    burst_cnt;

  logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];
  logic                  pick_found;
  logic [GRANT_W-1:0]    pick_idx;
  logic                  g_valid;
  logic                  g_last;
  logic                  xfer_hs;
  logic                  burst_done;
  logic                  stall_expire;
  logic                  release_c;
  logic [GRANT_W-1:0]    next_ptr;

  // Split the packed request bus into one byte lane per requester.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    assign data_arr[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  rr_pick #(
    .N (NUM_REQ),
    .W (GRANT_W)
  ) u_pick (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign g_valid    = req_valid[grant_id];
  assign g_last     = req_last[grant_id];
  assign xfer_hs    = (state == S_XFER) && g_valid && out_ready;
  assign burst_done = (burst_cnt == BURST_W'(MAX_BURST - 1));
  assign release_c  = (xfer_hs && (g_last || burst_done)) || stall_expire;
  assign next_ptr   = (grant_id == GRANT_W'(NUM_REQ - 1)) ? '0 : grant_id + GRANT_W'(1);

`ifdef UART_ARB_TIMEOUT_EN
  localparam int unsigned STALL_W = $clog2(IDLE_TIMEOUT + 1);

  logic [STALL_W-1:0] stall_cnt;

  assign stall_expire = (state == S_XFER) && !g_valid &&
                        (stall_cnt == STALL_W'(IDLE_TIMEOUT - 1));

  // Count consecutive owner-idle cycles during a grant; any valid cycle restarts the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if ((state != S_XFER) || g_valid || stall_expire) begin
      stall_cnt <= '0;
    end else begin
      stall_cnt <= stall_cnt + STALL_W'(1);
    end
  end
`else
  assign stall_expire = 1'b0;
`endif

  // Grant FSM: pick an owner in IDLE, hold it through the packet or burst cap, then rotate.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      rr_ptr    <= '0;
      grant_id  <= '0;
      burst_cnt <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pick_found) begin
            grant_id  <= pick_idx;
            busy      <= 1'b1;
            burst_cnt <= '0;
            state     <= S_XFER;
          end
        end
        S_XFER: begin
          if (xfer_hs) begin
            burst_cnt <= burst_cnt + BURST_W'(1);
          end
          if (release_c) begin
            rr_ptr <= next_ptr;
            busy   <= 1'b0;
            state  <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Pass the owner's handshake straight through; nothing moves while IDLE.
  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    req_ready = '0;
    if (state == S_XFER) begin
      out_valid           = g_valid;
      out_data            = data_arr[grant_id];
      req_ready[grant_id] = out_ready;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter (NUM_REQ=4, MAX_BURST=4, IDLE_TIMEOUT=8).
// Expectations for the stall scenario follow the UART_ARB_TIMEOUT_EN build macro.
module tb_uart_tx_arbiter;

  localparam int unsigned NR = 4;
  localparam int unsigned DW = 8;
  localparam int unsigned MB = 4;
  localparam int unsigned IT = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [NR-1:0] req_valid;
  logic [NR-1:0] req_ready;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0] req_last;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [1:0]    grant_id;
  logic          busy;

  uart_tx_arbiter #(
    .NUM_REQ      (NR),
    .DATA_WIDTH   (DW),
    .MAX_BURST    (MB),
    .IDLE_TIMEOUT (IT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .req_last  (req_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_err = 0;
  int n_chk = 0;

  typedef struct {
    logic        pre_rst;
    logic [3:0]  vld;
    logic [31:0] data;
    logic [3:0]  last;
    logic        ordy;
    logic        e_busy;
    logic [1:0]  e_gid;
    logic        e_ov;
    logic [7:0]  e_od;
    logic [3:0]  e_rdy;
  } vec_t;

  vec_t tv [16];

  // Requester source model: per-requester byte list {last, data}.
  logic [8:0] src_mem [4][16];
  int         src_len [4];
  int         src_pos [4];
  bit         src_en  [4];

  // Observed and expected accepted-byte streams.
  logic [1:0] obs_g [64];
  logic [7:0] obs_d [64];
  int         obs_n;
  logic [1:0] exp_g [64];
  logic [7:0] exp_d [64];
  int         exp_n;

  // Values sampled mid-cycle by cycle_src.
  logic       s_busy, s_ov;
  logic [1:0] s_gid, s_rr;
  logic [7:0] s_od, s_burst;
  logic [3:0] s_rdy;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic p, input logic [3:0] vld, input logic [31:0] data,
                              input logic [3:0] last, input logic ordy, input logic e_busy,
                              input logic [1:0] e_gid, input logic e_ov, input logic [7:0] e_od,
                              input logic [3:0] e_rdy);
    vec_t v;
    v.pre_rst = p;  v.vld = vld;  v.data = data;  v.last = last;  v.ordy = ordy;
    v.e_busy = e_busy;  v.e_gid = e_gid;  v.e_ov = e_ov;  v.e_od = e_od;  v.e_rdy = e_rdy;
    return v;
  endfunction

  task automatic load(input int r, input int n, input logic [7:0] base);
    for (int k = 0; k < n; k++) src_mem[r][k] = {(k == n - 1), 8'(base + 8'(k))};
    src_len[r] = n;
    src_pos[r] = 0;
    src_en[r]  = 1'b1;
  endtask

  // One clock of the source model: drive at negedge, sample, retire handshakes.
  task automatic cycle_src(input bit ordy, input bit do_rst);
    @(negedge clk);
    rst       = do_rst;
    out_ready = ordy;
    for (int i = 0; i < 4; i++) begin
      if (src_en[i] && src_pos[i] < src_len[i]) begin
        req_valid[i]       = 1'b1;
        req_data[i*8 +: 8] = src_mem[i][src_pos[i]][7:0];
        req_last[i]        = src_mem[i][src_pos[i]][8];
      end else begin
        req_valid[i]       = 1'b0;
        req_data[i*8 +: 8] = 8'h00;
        req_last[i]        = 1'b0;
      end
    end
    #1;
    s_busy  = busy;     s_ov  = out_valid;  s_od  = out_data;
    s_gid   = grant_id; s_rdy = req_ready;
    s_rr    = dut.rr_ptr;
    s_burst = dut.burst_cnt;
    chk("ready_leak", 32'(req_ready & ~(4'b0001 << grant_id)), 32'd0);
    if (out_valid && out_ready && obs_n < 64) begin
      obs_g[obs_n] = grant_id;
      obs_d[obs_n] = out_data;
      obs_n++;
    end
    for (int i = 0; i < 4; i++) if (req_valid[i] && req_ready[i]) src_pos[i]++;
    @(posedge clk);
  endtask

  task automatic do_reset();
    for (int i = 0; i < 4; i++) begin src_len[i] = 0; src_pos[i] = 0; src_en[i] = 1'b1; end
    cycle_src(1'b0, 1'b1);
    cycle_src(1'b0, 1'b1);
  endtask

  task automatic run_until_obs(input int n, input int budget);
    int k = 0;
    while (obs_n < n && k < budget) begin
      cycle_src(1'b1, 1'b0);
      k++;
    end
    chk("wait_obs", 32'(obs_n), 32'(n));
  endtask

  task automatic exp_push(input logic [1:0] g, input logic [7:0] d);
    exp_g[exp_n] = g;
    exp_d[exp_n] = d;
    exp_n++;
  endtask

  task automatic chk_stream(input string nm);
    chk($sformatf("%s_count", nm), 32'(obs_n), 32'(exp_n));
    for (int i = 0; i < exp_n; i++)
      chk($sformatf("%s_byte%0d", nm, i), 32'({obs_g[i], obs_d[i]}), 32'({exp_g[i], exp_d[i]}));
  endtask

  task automatic apply_vec(input int idx);
    vec_t v = tv[idx];
    if (v.pre_rst) do_reset();
    @(negedge clk);
    rst = 1'b0;  req_valid = v.vld;  req_data = v.data;  req_last = v.last;  out_ready = v.ordy;
    #1;
    chk($sformatf("v%0d_busy", idx), 32'(busy), 32'(v.e_busy));
    chk($sformatf("v%0d_gid", idx), 32'(grant_id), 32'(v.e_gid));
    chk($sformatf("v%0d_ovalid", idx), 32'(out_valid), 32'(v.e_ov));
    chk($sformatf("v%0d_odata", idx), 32'(out_data), 32'(v.e_od));
    chk($sformatf("v%0d_ready", idx), 32'(req_ready), 32'(v.e_rdy));
    if (v.pre_rst) begin
      chk($sformatf("v%0d_rr_reset", idx), 32'(dut.rr_ptr), 32'd0);
      chk($sformatf("v%0d_burst_reset", idx), 32'(dut.burst_cnt), 32'd0);
    end
    @(posedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;  req_valid = '0;  req_data = '0;  req_last = '0;  out_ready = 1'b0;
    obs_n = 0;   exp_n = 0;
    for (int i = 0; i < 4; i++) begin src_len[i] = 0; src_pos[i] = 0; src_en[i] = 1'b1; end

    // Single requester 1: A1 A2 A3, then contention of four 1-byte packets from reset.
    tv[0]  = mk(1, 4'b0000, 32'h0000_0000, 4'b0000, 1, 0, 2'd0, 0, 8'h00, 4'b0000);
    tv[1]  = mk(0, 4'b0010, 32'h0000_A100, 4'b0000, 1, 0, 2'd0, 0, 8'h00, 4'b0000);
    tv[2]  = mk(0, 4'b0010, 32'h0000_A100, 4'b0000, 1, 1, 2'd1, 1, 8'hA1, 4'b0010);
    tv[3]  = mk(0, 4'b0010, 32'h0000_A200, 4'b0000, 1, 1, 2'd1, 1, 8'hA2, 4'b0010);
    tv[4]  = mk(0, 4'b0010, 32'h0000_A300, 4'b0010, 1, 1, 2'd1, 1, 8'hA3, 4'b0010);
    tv[5]  = mk(0, 4'b0000, 32'h0000_0000, 4'b0000, 1, 0, 2'd1, 0, 8'h00, 4'b0000);
    tv[6]  = mk(1, 4'b1111, 32'h1312_1110, 4'b1111, 1, 0, 2'd0, 0, 8'h00, 4'b0000);
    tv[7]  = mk(0, 4'b1111, 32'h1312_1110, 4'b1111, 1, 1, 2'd0, 1, 8'h10, 4'b0001);
    tv[8]  = mk(0, 4'b1111, 32'h1312_1110, 4'b1111, 1, 0, 2'd0, 0, 8'h00, 4'b0000);
    tv[9]  = mk(0, 4'b1111, 32'h1312_1110, 4'b1111, 1, 1, 2'd1, 1, 8'h11, 4'b0010);
    tv[10] = mk(0, 4'b1111, 32'h1312_1110, 4'b1111, 1, 0, 2'd1, 0, 8'h00, 4'b0000);
    tv[11] = mk(0, 4'b1111, 32'h1312_1110, 4'b1111, 1, 1, 2'd2, 1, 8'h12, 4'b0100);
    tv[12] = mk(0, 4'b1111, 32'h1312_1110, 4'b1111, 1, 0, 2'd2, 0, 8'h00, 4'b0000);
    tv[13] = mk(0, 4'b1111, 32'h1312_1110, 4'b1111, 1, 1, 2'd3, 1, 8'h13, 4'b1000);
    tv[14] = mk(0, 4'b0000, 32'h0000_0000, 4'b0000, 1, 0, 2'd3, 0, 8'h00, 4'b0000);

    for (int i = 0; i <= 5; i++) apply_vec(i);
    chk("single_rr_ptr", 32'(dut.rr_ptr), 32'd2);
    for (int i = 6; i <= 14; i++) apply_vec(i);

    // Burst cap: req2 10-byte packet split at 4 bytes, req3 served in between.
    do_reset();
    obs_n = 0;  exp_n = 0;
    load(2, 10, 8'h20);
    load(3, 1, 8'h30);
    run_until_obs(11, 200);
    for (int k = 0; k < 4; k++) exp_push(2'd2, 8'(8'h20 + 8'(k)));
    exp_push(2'd3, 8'h30);
    for (int k = 4; k < 10; k++) exp_push(2'd2, 8'(8'h20 + 8'(k)));
    chk_stream("burst");

    // Backpressure: out_ready low for 20 cycles with byte 0x41 presented.
    obs_n = 0;  exp_n = 0;
    load(0, 4, 8'h40);
    run_until_obs(1, 50);
    for (int k = 0; k < 20; k++) begin
      cycle_src(1'b0, 1'b0);
      chk("bp_valid", 32'(s_ov), 32'd1);
      chk("bp_data", 32'(s_od), 32'h41);
      chk("bp_ready", 32'(s_rdy), 32'd0);
      chk("bp_burst", 32'(s_burst), 32'd1);
    end
    run_until_obs(4, 50);
    for (int k = 0; k < 4; k++) exp_push(2'd0, 8'(8'h40 + 8'(k)));
    chk_stream("bp");

    // Reset after 2 of 5 bytes from req2; afterwards requester 0 is served first.
    obs_n = 0;  exp_n = 0;
    load(2, 5, 8'h50);
    run_until_obs(2, 50);
    load(0, 1, 8'h60);
    cycle_src(1'b0, 1'b1);
    obs_n = 0;
    cycle_src(1'b1, 1'b0);
    chk("rst_busy", 32'(s_busy), 32'd0);
    chk("rst_ovalid", 32'(s_ov), 32'd0);
    chk("rst_gid", 32'(s_gid), 32'd0);
    chk("rst_rr", 32'(s_rr), 32'd0);
    run_until_obs(4, 50);
    exp_push(2'd0, 8'h60);
    exp_push(2'd2, 8'h52);
    exp_push(2'd2, 8'h53);
    exp_push(2'd2, 8'h54);
    chk_stream("rst");

    // Owner req1 stalls after its first byte while req2 waits.
    do_reset();
    obs_n = 0;  exp_n = 0;
    load(1, 3, 8'h70);
    load(2, 1, 8'h80);
    run_until_obs(1, 50);
    src_en[1] = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
    for (int k = 1; k <= 10; k++) begin
      cycle_src(1'b1, 1'b0);
      if (k <= 8) begin
        chk($sformatf("to_hold_busy%0d", k), 32'(s_busy), 32'd1);
        chk($sformatf("to_hold_gid%0d", k), 32'(s_gid), 32'd1);
      end else if (k == 9) begin
        chk("to_release_busy", 32'(s_busy), 32'd0);
      end else begin
        chk("to_regrant_busy", 32'(s_busy), 32'd1);
        chk("to_regrant_gid", 32'(s_gid), 32'd2);
        chk("to_regrant_data", 32'(s_od), 32'h80);
      end
    end
    exp_push(2'd1, 8'h70);
    exp_push(2'd2, 8'h80);
    exp_push(2'd1, 8'h71);
    exp_push(2'd1, 8'h72);
`else
    for (int k = 1; k <= 12; k++) begin
      cycle_src(1'b1, 1'b0);
      chk($sformatf("hold_busy%0d", k), 32'(s_busy), 32'd1);
      chk($sformatf("hold_gid%0d", k), 32'(s_gid), 32'd1);
      chk($sformatf("hold_ovalid%0d", k), 32'(s_ov), 32'd0);
    end
    exp_push(2'd1, 8'h70);
    exp_push(2'd1, 8'h71);
    exp_push(2'd1, 8'h72);
    exp_push(2'd2, 8'h80);
`endif
    src_en[1] = 1'b1;
    run_until_obs(4, 60);
    chk_stream("stall");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
